// File: rtl/rock_ramp_sequencer_if.sv
// Target and setpoint bundle shared by the rocking controller (master),
// the ramp sequencer (slave) and the output driver stage.
interface rock_ramp_sequencer_if;
    logic       tgt_valid;
    logic [2:0] tgt_amp;
    logic [2:0] tgt_freq;
    logic [2:0] amp;
    logic [2:0] freq;
    logic       busy;
    logic       settled;
    logic       error;

    modport master (
        output tgt_valid, tgt_amp, tgt_freq,
        input  amp, freq, busy, settled, error
    );

    modport slave (
        input  tgt_valid, tgt_amp, tgt_freq,
        output amp, freq, busy, settled, error
    );
endinterface

// File: rtl/rock_ramp_sequencer.sv
// Walks the live amplitude/frequency setpoints toward the requested target one
// step per STEP_TICKS ticks, changing frequency only while amplitude is low.
module rock_ramp_sequencer #(
    parameter int unsigned STEP_TICKS = 4,
    parameter int unsigned FSW_AMP    = 1,
    parameter int unsigned MAX_LEVEL  = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  tick,
    rock_ramp_sequencer_if.slave  bus
);

    localparam int unsigned   CW       = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(STEP_TICKS - 1);
    localparam logic [2:0]    FSW_CODE = 3'(FSW_AMP);
    localparam logic [2:0]    MAX_CODE = 3'(MAX_LEVEL);

    typedef enum logic [1:0] {IDLE, DOWN, FSW, ADJ} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] step_cnt;
    logic [CW-1:0] step_cnt_nxt;
    logic [2:0]    amp_q;
    logic [2:0]    freq_q;
    logic [2:0]    amp_nxt;
    logic [2:0]    freq_nxt;
    logic [2:0]    pend_amp;
    logic [2:0]    pend_freq;
    logic          error_q;
    logic          step;

    function automatic logic [2:0] clamp(input logic [2:0] code);
        return (code > MAX_CODE) ? MAX_CODE : code;
    endfunction

    // A frequency change starts with an amplitude ramp-down unless already low enough.
    function automatic state_t freq_entry(input logic [2:0] a);
        return (a > FSW_CODE) ? DOWN : FSW;
    endfunction

    assign step = (state != IDLE) && tick && (step_cnt == CNT_LAST);

    always_comb begin
        state_nxt = state;
        amp_nxt   = amp_q;
        freq_nxt  = freq_q;
        case (state)
            IDLE: begin
                if (freq_q != pend_freq)
                    state_nxt = freq_entry(amp_q);
                else if (amp_q != pend_amp)
                    state_nxt = ADJ;
            end
            DOWN: begin
                if (freq_q == pend_freq)
                    state_nxt = ADJ;
                else if (amp_q <= FSW_CODE)
                    state_nxt = FSW;
                else if (step)
                    amp_nxt = amp_q - 3'd1;
            end
            FSW: begin
                if (freq_q == pend_freq)
                    state_nxt = ADJ;
                else if (step)
                    freq_nxt = (pend_freq > freq_q) ? freq_q + 3'd1 : freq_q - 3'd1;
            end
            ADJ: begin
                if (freq_q != pend_freq)
                    state_nxt = freq_entry(amp_q);
                else if (amp_q == pend_amp)
                    state_nxt = IDLE;
                else if (step)
                    amp_nxt = (pend_amp > amp_q) ? amp_q + 3'd1 : amp_q - 3'd1;
            end
            default: state_nxt = IDLE;
        endcase

        step_cnt_nxt = step_cnt;
        if ((state == IDLE) || (state_nxt != state) || step)
            step_cnt_nxt = '0;
        else if (tick)
            step_cnt_nxt = step_cnt + CW'(1);
    end

    // Targets are captured in any state; a step on the same edge still sees the old target.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            step_cnt  <= '0;
            amp_q     <= 3'd0;
            freq_q    <= 3'd0;
            pend_amp  <= 3'd0;
            pend_freq <= 3'd0;
            error_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            step_cnt <= step_cnt_nxt;
            amp_q    <= amp_nxt;
            freq_q   <= freq_nxt;
            if (bus.tgt_valid) begin
                pend_amp  <= clamp(bus.tgt_amp);
                pend_freq <= clamp(bus.tgt_freq);
                error_q   <= (bus.tgt_amp > MAX_CODE) || (bus.tgt_freq > MAX_CODE);
            end
        end
    end

    assign bus.amp     = amp_q;
    assign bus.freq    = freq_q;
    assign bus.busy    = (state != IDLE);
    assign bus.settled = (state == IDLE) && (amp_q == pend_amp) && (freq_q == pend_freq);
    assign bus.error   = error_q;

endmodule

// File: tb/tb_rock_ramp_sequencer.sv
// Directed bench for rock_ramp_sequencer: STEP_TICKS=4, FSW_AMP=1, tick every 8 clk.
module tb_rock_ramp_sequencer;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic tick  = 1'b0;
    int   div   = 0;
    int   total = 0;
    int   bad   = 0;

    rock_ramp_sequencer_if bus_if();

    rock_ramp_sequencer #(
        .STEP_TICKS (4),
        .FSW_AMP    (1),
        .MAX_LEVEL  (6)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .tick  (tick),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        tick = (div == 7);
        div  = (div + 1) % 8;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Frequency may only move while the amplitude seen before the edge was low.
    logic [2:0] prev_amp  = 3'd0;
    logic [2:0] prev_freq = 3'd0;
    logic       mon_skip  = 1'b1;
    always begin
        @(posedge clk);
        #1;
        if (!reset && !mon_skip && (bus_if.freq !== prev_freq))
            checkOutput("freq_safe", 32'(prev_amp <= 3'd1), 32'd1);
        mon_skip  = reset;
        prev_amp  = bus_if.amp;
        prev_freq = bus_if.freq;
    end

    task automatic applyStimulus(input logic [2:0] a, input logic [2:0] f);
        @(negedge clk);
        bus_if.tgt_valid = 1'b1;
        bus_if.tgt_amp   = a;
        bus_if.tgt_freq  = f;
        @(negedge clk);
        bus_if.tgt_valid = 1'b0;
    endtask

    task automatic syncTick();
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            if (tick) break;
        end
    endtask

    task automatic expectStep(input string tag, input logic [2:0] a, input logic [2:0] f);
        logic [2:0] a0;
        logic [2:0] f0;
        int         n;
        bit         moved;
        a0    = bus_if.amp;
        f0    = bus_if.freq;
        n     = 0;
        moved = 1'b0;
        for (int i = 0; i < 100 && !moved; i++) begin
            @(posedge clk);
            if (tick) n++;
            #1;
            moved = (bus_if.amp !== a0) || (bus_if.freq !== f0);
        end
        checkOutput({tag, " moved"}, 32'(moved), 32'd1);
        checkOutput({tag, " amp"},   32'(bus_if.amp),  32'(a));
        checkOutput({tag, " freq"},  32'(bus_if.freq), 32'(f));
        checkOutput({tag, " ticks"}, 32'(n), 32'd4);
    endtask

    // Each entry is two octal digits: amplitude then frequency.
    task automatic expectSeq(input string tag, input logic [5:0] seq[$]);
        foreach (seq[i])
            expectStep($sformatf("%s[%0d]", tag, i), seq[i][5:3], seq[i][2:0]);
    endtask

    task automatic settleCheck(input string tag);
        repeat (2) @(posedge clk);
        #1;
        checkOutput({tag, " busy"},    32'(bus_if.busy),    32'd0);
        checkOutput({tag, " settled"}, 32'(bus_if.settled), 32'd1);
    endtask

    initial begin
        logic [5:0] q[$];
        int         seen;

        bus_if.tgt_valid = 1'b0;
        bus_if.tgt_amp   = 3'd0;
        bus_if.tgt_freq  = 3'd0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("rst amp",     32'(bus_if.amp),     32'd0);
        checkOutput("rst freq",    32'(bus_if.freq),    32'd0);
        checkOutput("rst busy",    32'(bus_if.busy),    32'd0);
        checkOutput("rst settled", 32'(bus_if.settled), 32'd1);
        checkOutput("rst error",   32'(bus_if.error),   32'd0);

        $display("[TB] ramp up to (5,0)");
        syncTick();
        applyStimulus(3'd5, 3'd0);
        checkOutput("up settled_low", 32'(bus_if.settled), 32'd0);
        q = '{6'o10, 6'o20, 6'o30, 6'o40, 6'o50};
        expectSeq("up", q);
        settleCheck("up");
        repeat (40) @(posedge clk);
        #1;
        checkOutput("idle tick amp",  32'(bus_if.amp),  32'd5);
        checkOutput("idle tick busy", 32'(bus_if.busy), 32'd0);

        $display("[TB] frequency change to (5,2)");
        syncTick();
        applyStimulus(3'd5, 3'd2);
        q = '{6'o40, 6'o30, 6'o20, 6'o10, 6'o11, 6'o12, 6'o22, 6'o32, 6'o42, 6'o52};
        expectSeq("f2", q);
        settleCheck("f2");

        $display("[TB] frequency change at swing to (5,4)");
        syncTick();
        applyStimulus(3'd5, 3'd4);
        q = '{6'o42, 6'o32, 6'o22, 6'o12, 6'o13, 6'o14, 6'o24, 6'o34, 6'o44, 6'o54};
        expectSeq("f4", q);
        settleCheck("f4");

        $display("[TB] illegal target (7,3)");
        syncTick();
        applyStimulus(3'd7, 3'd3);
        checkOutput("ill error", 32'(bus_if.error), 32'd1);
        q = '{6'o44, 6'o34, 6'o24, 6'o14, 6'o13, 6'o23, 6'o33, 6'o43, 6'o53, 6'o63};
        expectSeq("ill", q);
        settleCheck("ill");
        checkOutput("ill amp_clamped", 32'(bus_if.amp), 32'd6);

        syncTick();
        applyStimulus(3'd2, 3'd3);
        checkOutput("legal error", 32'(bus_if.error), 32'd0);
        q = '{6'o53, 6'o43, 6'o33, 6'o23};
        expectSeq("legal", q);
        settleCheck("legal");

        $display("[TB] mid-ramp retarget");
        syncTick();
        applyStimulus(3'd5, 3'd3);
        expectStep("mid0", 3'd3, 3'd3);
        applyStimulus(3'd2, 3'd3);
        expectStep("mid1", 3'd2, 3'd3);
        settleCheck("mid");

        $display("[TB] target on the step edge");
        syncTick();
        applyStimulus(3'd5, 3'd3);
        expectStep("sim0", 3'd3, 3'd3);
        seen = 0;
        for (int i = 0; i < 100 && seen < 3; i++) begin
            @(posedge clk);
            if (tick) seen++;
        end
        repeat (7) @(posedge clk);
        @(negedge clk);
        bus_if.tgt_valid = 1'b1;
        bus_if.tgt_amp   = 3'd2;
        bus_if.tgt_freq  = 3'd3;
        @(posedge clk);
        #1;
        checkOutput("sim old_target amp", 32'(bus_if.amp), 32'd4);
        @(negedge clk);
        bus_if.tgt_valid = 1'b0;
        q = '{6'o33, 6'o23};
        expectSeq("sim", q);
        settleCheck("sim");

        $display("[TB] target equal to setpoints");
        applyStimulus(3'd2, 3'd3);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("same busy",    32'(bus_if.busy),    32'd0);
        checkOutput("same settled", 32'(bus_if.settled), 32'd1);

        $display("[TB] asynchronous reset mid-ramp");
        syncTick();
        applyStimulus(3'd6, 3'd3);
        expectStep("ar0", 3'd3, 3'd3);
        #3;
        reset = 1'b1;
        #1;
        checkOutput("ar amp",     32'(bus_if.amp),     32'd0);
        checkOutput("ar freq",    32'(bus_if.freq),    32'd0);
        checkOutput("ar busy",    32'(bus_if.busy),    32'd0);
        checkOutput("ar settled", 32'(bus_if.settled), 32'd1);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        checkOutput("ar after amp",  32'(bus_if.amp),  32'd0);
        checkOutput("ar after busy", 32'(bus_if.busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
